// File: rtl/uart_rx.sv
// uart_rx: serial-to-parallel UART receiver (8N1, optional even parity, 1+ stop bits).
// Latency: pin to rx_pdata_valid_o is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (+CLKS_PER_BIT with parity).
// Backpressure: one-byte output register held until accepted; a good frame arriving while it is full is dropped with an rx_overrun_o pulse.
//
// Optional feature macro: UART_RX_PARITY_EN (adds an even-parity bit after the data bits).
// Ports:
//   rx_sclk_i         receive clock, rising edge
//   rx_srst_n_i       synchronous active-low reset
//   rx_sdata_i        serial line, asynchronous, idles high
//   rx_pdata_ready_i  consumer accepts rx_pdata_o when high with rx_pdata_valid_o
//   rx_pdata_o        received byte, bit 0 = first data bit on the line
//   rx_pdata_valid_o  rx_pdata_o holds an unconsumed byte
//   rx_frame_err_o    one-cycle pulse: bad stop bit (or bad parity)
//   rx_overrun_o      one-cycle pulse: good frame dropped, output still full
//   rx_busy_o         receiver FSM is not idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       rx_sclk_i,
    input  logic       rx_srst_n_i,
    input  logic       rx_sdata_i,
    input  logic       rx_pdata_ready_i,
    output logic [7:0] rx_pdata_o,
    output logic       rx_pdata_valid_o,
    output logic       rx_frame_err_o,
    output logic       rx_overrun_o,
    output logic       rx_busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic            sync1_q, sd_q, prev_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      pdata_q, pdata_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;
    logic            busy_q;
    logic            frame_ok;
`ifdef UART_RX_PARITY_EN
    logic            par_err_q, par_err_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        pdata_d  = pdata_q;
        // An accepted byte drops valid on the next cycle unless a new one replaces it below.
        valid_d  = valid_q && !rx_pdata_ready_i;
        ferr_d   = 1'b0;
        ovr_d    = 1'b0;
        frame_ok = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // Falling edge only: a line stuck low never starts a frame.
                if (prev_q && !sd_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF) begin
                    cnt_d = '0;
                    bit_d = '0;
                    state_d = sd_q ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
                    par_err_d = 1'b0;
`endif
                end
            end
            S_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    shift_d = {sd_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL) begin
                    cnt_d     = '0;
                    par_err_d = ^{sd_q, shift_q};
                    state_d   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
                    frame_ok = sd_q && !par_err_q;
`else
                    frame_ok = sd_q;
`endif
                    ferr_d = !frame_ok;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (frame_ok) begin
            // Full-and-ready in the same cycle swaps bytes with no overrun.
            if (!valid_q || rx_pdata_ready_i) begin
                pdata_d = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rx_sclk_i) begin
        if (!rx_srst_n_i) begin
            state_q <= S_IDLE;
            sync1_q <= 1'b1;
            sd_q    <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            pdata_q <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sync1_q <= rx_sdata_i;
            sd_q    <= sync1_q;
            prev_q  <= sd_q;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            pdata_q <= pdata_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= (state_d != S_IDLE);
`ifdef UART_RX_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    assign rx_pdata_o       = pdata_q;
    assign rx_pdata_valid_o = valid_q;
    assign rx_frame_err_o   = ferr_q;
    assign rx_overrun_o     = ovr_q;
    assign rx_busy_o        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed frames against a frame-level reference model.
// Stimulus pushes expected bytes / error pulses / overrun pulses into queues;
// a monitor pops and compares whenever the DUT presents them.
module tb_uart_rx;

    localparam int C = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    // Pin-to-valid latency in cycles.
    localparam int LAT = 2 + C / 2 + 9 * C + 1 + (PAR_EN ? C : 0);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sdata = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] pdata;
    logic       valid, ferr, ovr, busy;

    int n_vec = 0;
    int n_bad = 0;
    int cycle = 0;
    int rise_cycle = -1;
    logic valid_prev = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] ferr_q[$];
    logic [7:0] ovr_q[$];

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .rx_sclk_i       (clk),
        .rx_srst_n_i     (rst_n),
        .rx_sdata_i      (sdata),
        .rx_pdata_ready_i(ready),
        .rx_pdata_o      (pdata),
        .rx_pdata_valid_o(valid),
        .rx_frame_err_o  (ferr),
        .rx_overrun_o    (ovr),
        .rx_busy_o       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input bit ok, input string name, input int act, input int req);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Reference model: a frame is good iff its stop bit is 1 and (when enabled) its
    // parity is correct; a good frame either lands in the output or overruns.
    task automatic expect_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad,
                                input bit out_full);
        if (!stop_ok || (PAR_EN && par_bad)) ferr_q.push_back(d);
        else if (out_full)                   ovr_q.push_back(d);
        else                                 exp_q.push_back(d);
    endtask

    // Drives one frame starting at a negedge; returns at a negedge with the line high.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_bad);
        sdata = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sdata = d[i];
            repeat (C) @(negedge clk);
        end
        if (PAR_EN) begin
            sdata = (^d) ^ par_bad;
            repeat (C) @(negedge clk);
        end
        sdata = stop_ok;
        repeat (C) @(negedge clk);
        sdata = 1'b1;
    endtask

    // Monitor: samples mid-low-phase, away from both clock edges and stimulus updates.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            if (valid && ready) begin
                if (exp_q.size() == 0) check(1'b0, "unexpected_byte", pdata, 0);
                else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check(pdata == e, "byte", pdata, e);
                end
            end
            if (ferr) begin
                if (ferr_q.size() == 0) check(1'b0, "unexpected_frame_err", 1, 0);
                else begin
                    logic [7:0] e;
                    e = ferr_q.pop_front();
                    check(!valid || valid_prev, "frame_err_no_new_valid", valid, valid_prev);
                end
            end
            if (ovr) begin
                if (ovr_q.size() == 0) check(1'b0, "unexpected_overrun", 1, 0);
                else begin
                    logic [7:0] e;
                    e = ovr_q.pop_front();
                    check(pdata != e, "overrun_kept_old", pdata, e);
                end
            end
            if (valid && !valid_prev) rise_cycle = cycle;
            valid_prev = valid;
        end else begin
            valid_prev = 1'b0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cycle);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit seen;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;

        // Idle line after reset: everything quiet for 500 cycles.
        for (int blk = 0; blk < 5; blk++) begin
            bit quiet;
            quiet = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (valid || ferr || ovr || busy || pdata != 8'h00) quiet = 1'b0;
            end
            check(quiet, "reset_idle_quiet", {pdata, 4'(0), valid, ferr, ovr, busy}, 0);
        end

        // First frame: latency and one-cycle valid with ready held high.
        @(negedge clk);
        expect_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        t0 = cycle;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (C) @(negedge clk);
        check(rise_cycle - t0 == LAT, "latency", rise_cycle - t0, LAT);

        // Short low glitch: false start, no output.
        sdata = 1'b0;
        repeat (4) @(negedge clk);
        sdata = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 3 * C; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check(seen, "glitch_start_entered", seen, 1);
        check(!busy && !valid, "glitch_back_idle", {busy, valid}, 0);

        // Bad stop bit, then a good frame after the line returns high.
        expect_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (C) @(negedge clk);
        check(!valid, "frame_err_no_valid", valid, 0);
        expect_frame(8'h81, 1'b1, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (C) @(negedge clk);

        // Back-to-back frames while the consumer stalls.
        ready = 1'b0;
        expect_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0);
        expect_frame(8'h22, 1'b1, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        repeat (C) @(negedge clk);
        check(valid && pdata == 8'h11, "held_byte", {valid, pdata}, {1'b1, 8'h11});
        ready = 1'b1;
        repeat (2) @(negedge clk);
        check(!valid, "valid_drop_after_accept", valid, 0);

        // Reset in the middle of data bit 4 abandons the frame silently.
        sdata = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            sdata = i[0];
            repeat (C) @(negedge clk);
        end
        sdata = 1'b1;
        repeat (C / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check(!busy && !valid && !ferr, "mid_frame_reset", {busy, valid, ferr}, 0);
        rst_n = 1'b1;
        repeat (2 * C) @(negedge clk);
        check(!busy, "idle_after_reset", busy, 0);
        expect_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b1, 1'b0);
        repeat (C) @(negedge clk);

        if (PAR_EN) begin
            expect_frame(8'h07, 1'b1, 1'b1, 1'b0);
            send_frame(8'h07, 1'b1, 1'b1);
            repeat (C) @(negedge clk);
            check(!valid, "parity_err_no_valid", valid, 0);
        end

        // Randomized frames, including bad stops, bad parity and zero-gap back-to-back.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            bit stop_ok, par_bad;
            int gap;
            d       = 8'($urandom);
            stop_ok = ($urandom_range(0, 7) != 0);
            par_bad = ($urandom_range(0, 7) == 0);
            expect_frame(d, stop_ok, par_bad, 1'b0);
            send_frame(d, stop_ok, par_bad);
            gap = stop_ok ? $urandom_range(0, 2 * C) : $urandom_range(C, 2 * C);
            repeat (gap) @(negedge clk);
        end

        repeat (2 * C) @(negedge clk);
        check(exp_q.size() == 0, "bytes_outstanding", exp_q.size(), 0);
        check(ferr_q.size() == 0, "frame_err_outstanding", ferr_q.size(), 0);
        check(ovr_q.size() == 0, "overrun_outstanding", ovr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
